// File: rtl/reg_pipe.sv
// Elastic pipeline register: DEPTH signed stages with valid/ready flow control,
// bubble collapsing, synchronous flush and asynchronous active-low reset.
module reg_pipe #(
  parameter  int WL    = 32,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [WL-1:0] in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [WL-1:0] out,
  output logic [CW-1:0]        count
);

  logic [DEPTH-1:0]     vld_p;
  logic signed [WL-1:0] dat_p [DEPTH];
  logic [DEPTH-1:0]     rdy;
  logic [DEPTH-1:0]     src_v;
  logic signed [WL-1:0] src_d [DEPTH];

  function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  // Stage i may load unless it and every stage after it is full and the
  // sink is stalled; written flat so no combinational ripple loop is built.
  function automatic logic stage_rdy(input logic [DEPTH-1:0] v, input logic ordy,
                                     input int i);
    logic [DEPTH-1:0] ones;
    ones = {DEPTH{1'b1}} >> i;
    return ordy | ((v >> i) != ones);
  endfunction

  always_comb begin
    src_v[0] = in_valid;
    src_d[0] = in;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = vld_p[i-1];
      src_d[i] = dat_p[i-1];
    end
    for (int i = 0; i < DEPTH; i++) rdy[i] = stage_rdy(vld_p, out_ready, i);
  end

  // Stage registers: flush kills every valid bit but leaves data untouched
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p <= '0;
      for (int i = 0; i < DEPTH; i++) dat_p[i] <= '0;
    end else if (flush) begin
      vld_p <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) begin
          vld_p[i] <= src_v[i];
          if (src_v[i]) dat_p[i] <= src_d[i];
        end
      end
    end
  end

  assign in_ready  = rdy[0] & ~flush & rst;
  assign out_valid = vld_p[DEPTH-1];
  assign out       = dat_p[DEPTH-1];
  assign count     = popcount(vld_p);

endmodule

// File: tb/tb_reg_pipe.sv
// Bench for reg_pipe: directed scenarios on a WL=8/DEPTH=3 instance plus a
// randomized run on DEPTH=1,2,4 instances against a queue-of-words model.
module tb_reg_pipe;

  logic clk;
  logic rst, flush, in_valid, out_ready;
  logic signed [7:0] din;

  logic rdy3, ov3, rdy1, ov1, rdy2, ov2, rdy4, ov4;
  logic signed [7:0] o3, o1, o2, o4;
  logic [1:0] cnt3, cnt2;
  logic [0:0] cnt1;
  logic [2:0] cnt4;

  int nchk = 0;
  int nfail = 0;

  reg_pipe #(.WL(8), .DEPTH(3)) dut3 (.clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy3), .in(din), .out_valid(ov3),
    .out_ready(out_ready), .out(o3), .count(cnt3));
  reg_pipe #(.WL(8), .DEPTH(1)) dut1 (.clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1), .in(din), .out_valid(ov1),
    .out_ready(out_ready), .out(o1), .count(cnt1));
  reg_pipe #(.WL(8), .DEPTH(2)) dut2 (.clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy2), .in(din), .out_valid(ov2),
    .out_ready(out_ready), .out(o2), .count(cnt2));
  reg_pipe #(.WL(8), .DEPTH(4)) dut4 (.clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy4), .in(din), .out_valid(ov4),
    .out_ready(out_ready), .out(o4), .count(cnt4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic              ir_a [3];
  logic              ov_a [3];
  logic signed [7:0] o_a  [3];
  int                cnt_a[3];
  always_comb begin
    ir_a[0] = rdy1; ov_a[0] = ov1; o_a[0] = o1; cnt_a[0] = int'(cnt1);
    ir_a[1] = rdy2; ov_a[1] = ov2; o_a[1] = o2; cnt_a[1] = int'(cnt2);
    ir_a[2] = rdy4; ov_a[2] = ov4; o_a[2] = o4; cnt_a[2] = int'(cnt4);
  end

  // Model: per instance, an ordered list of words in flight (oldest first),
  // each with the stage it occupies, plus the last word that reached the output.
  int                dep [3] = '{1, 2, 4};
  logic signed [7:0] mw  [3][4];
  int                mp  [3][4];
  int                mn  [3];
  logic signed [7:0] mlast[3];

  task automatic model_step(input int k);
    int  d, prev_old;
    bit  acc, moved, left;
    d   = dep[k];
    acc = in_valid && !flush && !(mn[k] == d && !out_ready);
    if (flush) begin
      mn[k] = 0;
      return;
    end
    left = 0; moved = 0; prev_old = 0;
    for (int j = 0; j < mn[k]; j++) begin
      int op;
      op = mp[k][j];
      if (j == 0) begin
        if (op == d - 1) begin
          left  = out_ready;
          moved = out_ready;
        end else begin
          mp[k][j] = op + 1;
          moved = 1;
        end
      end else if (moved || op + 1 < prev_old) begin
        mp[k][j] = op + 1;
        moved = 1;
      end else begin
        moved = 0;
      end
      if (op != mp[k][j] && mp[k][j] == d - 1) mlast[k] = mw[k][j];
      prev_old = op;
    end
    if (left) begin
      for (int j = 1; j < mn[k]; j++) begin
        mw[k][j-1] = mw[k][j];
        mp[k][j-1] = mp[k][j];
      end
      mn[k] = mn[k] - 1;
    end
    if (acc) begin
      mw[k][mn[k]] = din;
      mp[k][mn[k]] = 0;
      mn[k] = mn[k] + 1;
      if (d == 1) mlast[k] = din;
    end
  endtask

  task automatic test_reset;
    rst = 0; flush = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      din = 8'($urandom); in_valid = 1'($urandom); out_ready = 1'($urandom);
      #1;
      nchk++;
      if (o3 !== 8'sd0 || ov3 !== 1'b0 || cnt3 !== 2'd0 || rdy3 !== 1'b0) begin
        nfail++;
        $display("FAIL reset_hold: out=%0d ov=%0b cnt=%0d in_ready=%0b want 0 0 0 0",
                 o3, ov3, cnt3, rdy3);
      end
    end
    @(negedge clk);
    rst = 1; in_valid = 0; out_ready = 0;
    #1;
    nchk++;
    if (rdy3 !== 1'b1) begin
      nfail++;
      $display("FAIL reset_release_ready: got %0b want 1", rdy3);
    end
    // Fill the pipe, then reset asynchronously mid-stream.
    @(negedge clk); in_valid = 1; din = 8'sd55;
    @(negedge clk); din = 8'sd66;
    @(negedge clk); din = 8'sd77;
    @(negedge clk); in_valid = 0;
    #1;
    nchk++;
    if (o3 !== 8'sd55 || cnt3 !== 2'd3) begin
      nfail++;
      $display("FAIL reset_prefill: out=%0d cnt=%0d want 55 3", o3, cnt3);
    end
    rst = 0;
    #1;
    nchk++;
    if (o3 !== 8'sd0 || ov3 !== 1'b0 || cnt3 !== 2'd0 || rdy3 !== 1'b0) begin
      nfail++;
      $display("FAIL reset_async: out=%0d ov=%0b cnt=%0d in_ready=%0b want 0 0 0 0",
               o3, ov3, cnt3, rdy3);
    end
    @(negedge clk); rst = 1;
  endtask

  task automatic test_stream;
    logic signed [7:0] vals [4];
    vals = '{8'shFB, 8'sh07, 8'sh7F, 8'sh80};
    @(negedge clk);
    out_ready = 1; flush = 0; in_valid = 1; din = vals[0];
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      nchk++;
      if (c >= 3 && c <= 6) begin
        if (ov3 !== 1'b1 || o3 !== vals[c-3]) begin
          nfail++;
          $display("FAIL stream_word%0d: ov=%0b out=%0d want 1 %0d", c - 3, ov3, o3, vals[c-3]);
        end
      end else if (ov3 !== 1'b0) begin
        nfail++;
        $display("FAIL stream_gap cycle %0d: ov=%0b want 0", c, ov3);
      end
      if (c < 4) din = vals[c];
      else in_valid = 0;
    end
  endtask

  task automatic test_backpressure;
    @(negedge clk); out_ready = 0; in_valid = 1; din = 8'sd1;
    @(negedge clk); din = 8'sd2;
    @(negedge clk); din = 8'sd3;
    @(negedge clk); in_valid = 0;
    repeat (2) begin
      #1;
      nchk++;
      if (cnt3 !== 2'd3 || rdy3 !== 1'b0 || ov3 !== 1'b1 || o3 !== 8'sd1) begin
        nfail++;
        $display("FAIL bp_full: cnt=%0d in_ready=%0b ov=%0b out=%0d want 3 0 1 1",
                 cnt3, rdy3, ov3, o3);
      end
      @(negedge clk);
    end
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      nchk++;
      if (ov3 !== 1'b1 || o3 !== 8'(i + 1) || int'(cnt3) != 3 - i) begin
        nfail++;
        $display("FAIL bp_drain%0d: ov=%0b out=%0d cnt=%0d want 1 %0d %0d",
                 i, ov3, o3, cnt3, i + 1, 3 - i);
      end
      @(negedge clk);
    end
    #1;
    nchk++;
    if (cnt3 !== 2'd0 || ov3 !== 1'b0) begin
      nfail++;
      $display("FAIL bp_empty: cnt=%0d ov=%0b want 0 0", cnt3, ov3);
    end
  endtask

  task automatic test_bubble;
    logic signed [7:0] exp_w [3];
    logic signed [7:0] got [$];
    exp_w = '{-8'sd3, 8'sd44, -8'sd100};
    @(negedge clk); out_ready = 1; in_valid = 1; din = exp_w[0];
    @(negedge clk); in_valid = 0;
    @(negedge clk);
    @(negedge clk); out_ready = 0; in_valid = 1; din = exp_w[1];
    @(negedge clk); din = exp_w[2];
    @(negedge clk); in_valid = 0;
    #1;
    nchk++;
    if (cnt3 !== 2'd3 || rdy3 !== 1'b0 || o3 !== exp_w[0]) begin
      nfail++;
      $display("FAIL bubble_fill: cnt=%0d in_ready=%0b out=%0d want 3 0 %0d",
               cnt3, rdy3, o3, exp_w[0]);
    end
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      if (ov3 && out_ready) got.push_back(o3);
      @(negedge clk);
      #1;
    end
    nchk++;
    if (got.size() != 3) begin
      nfail++;
      $display("FAIL bubble_count: got %0d words want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        nchk++;
        if (got[i] !== exp_w[i]) begin
          nfail++;
          $display("FAIL bubble_order%0d: got %0d want %0d", i, got[i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_flush;
    @(negedge clk); out_ready = 0; in_valid = 1; din = 8'sd10;
    @(negedge clk); din = 8'sd20;
    @(negedge clk); din = 8'sd30; flush = 1;
    #1;
    nchk++;
    if (rdy3 !== 1'b0 || cnt3 !== 2'd2) begin
      nfail++;
      $display("FAIL flush_pre: in_ready=%0b cnt=%0d want 0 2", rdy3, cnt3);
    end
    @(negedge clk); flush = 0; in_valid = 0;
    #1;
    nchk++;
    if (cnt3 !== 2'd0 || ov3 !== 1'b0) begin
      nfail++;
      $display("FAIL flush_clear: cnt=%0d ov=%0b want 0 0", cnt3, ov3);
    end
    out_ready = 1;
    repeat (5) begin
      @(negedge clk);
      nchk++;
      if (ov3 !== 1'b0 || o3 === 8'sd30) begin
        nfail++;
        $display("FAIL flush_leak: ov=%0b out=%0d want ov 0 and out not 30", ov3, o3);
      end
    end
  endtask

  task automatic test_random;
    @(negedge clk);
    rst = 0; flush = 0; in_valid = 0; out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      mn[k] = 0;
      mlast[k] = '0;
    end
    @(negedge clk);
    rst = 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      din       = 8'($urandom);
      #1;
      for (int k = 0; k < 3; k++) begin
        bit exp_ov, exp_ir;
        exp_ov = (mn[k] > 0) && (mp[k][0] == dep[k] - 1);
        exp_ir = !(mn[k] == dep[k] && !out_ready) && !flush;
        nchk++;
        if (cnt_a[k] != mn[k] || ov_a[k] !== exp_ov || ir_a[k] !== exp_ir ||
            o_a[k] !== mlast[k]) begin
          nfail++;
          $display("FAIL rand_d%0d cyc %0d: cnt=%0d ov=%0b ir=%0b out=%0d want %0d %0b %0b %0d",
                   dep[k], cyc, cnt_a[k], ov_a[k], ir_a[k], o_a[k],
                   mn[k], exp_ov, exp_ir, mlast[k]);
        end
        model_step(k);
      end
      @(negedge clk);
    end
    flush = 0; in_valid = 0;
  endtask

  initial begin
    rst = 0; flush = 0; in_valid = 0; out_ready = 0; din = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
